// File: rtl/jtag_debug_cmd_sysclk_gen_if.sv
// -----------------------------------------------------------------------------
// jtag_debug_cmd_sysclk_gen_if
// Command handshake between the sysclk side of the debug JTAG bridge and the
// CPU-side debug logic.
//   cmd_valid : command pending (driven by the bridge)
//   cmd_ready : consumer accepts the pending command
//   jdo       : captured DR contents, held while cmd_valid
//   cmd_ir    : IR value associated with the pending command
// master = bridge (producer), slave = debug logic (consumer).
// -----------------------------------------------------------------------------
interface jtag_debug_cmd_sysclk_gen_if #(
    parameter int unsigned IR_W = 2,
    parameter int unsigned DR_W = 38
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [DR_W-1:0] jdo;
    logic [IR_W-1:0] cmd_ir;

    modport master (
        output cmd_valid,
        output jdo,
        output cmd_ir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  jdo,
        input  cmd_ir,
        output cmd_ready
    );
endinterface

// File: rtl/jtag_debug_cmd_sysclk_gen.sv
// -----------------------------------------------------------------------------
// jtag_debug_cmd_sysclk_gen
// System-clock side of the debug-module JTAG bridge. Resynchronises the
// toggle-encoded update-IR / update-DR events from the TCK domain, holds each
// DR update as a command behind a valid/ready handshake, decodes one-hot
// action / no-action pulses on accept and counts DR updates dropped because a
// command was still pending.
//
// Ports:
//   clk, reset_n         : system clock, asynchronous active-low reset
//   vs_uir_tgl           : toggles once per TCK-domain update-IR
//   vs_udr_tgl           : toggles once per TCK-domain update-DR
//   ir_in  [IR_W]        : TCK-domain IR, quasi-static around its toggle
//   sr     [DR_W]        : TCK-domain shift register, quasi-static around its toggle
//   cmd (master)         : cmd_valid / cmd_ready / jdo / cmd_ir handshake
//   ir_upd               : one-cycle pulse per IR update
//   take_action [2**IR_W]    : one-hot pulse after accept when jdo MSB = 1
//   take_no_action [2**IR_W] : one-hot pulse after accept when jdo MSB = 0
//   overrun              : sticky, a DR update was dropped
//   ovr_cnt [CNT_W]      : saturating count of dropped DR updates
//   clr_overrun          : synchronous clear of overrun and ovr_cnt
// -----------------------------------------------------------------------------
module jtag_debug_cmd_sysclk_gen #(
    parameter int unsigned IR_W        = 2,
    parameter int unsigned DR_W        = 38,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   vs_uir_tgl,
    input  logic                   vs_udr_tgl,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [DR_W-1:0]        sr,
    jtag_debug_cmd_sysclk_gen_if.master cmd,
    output logic                   ir_upd,
    output logic [(1<<IR_W)-1:0]   take_action,
    output logic [(1<<IR_W)-1:0]   take_no_action,
    output logic                   overrun,
    output logic [CNT_W-1:0]       ovr_cnt,
    input  logic                   clr_overrun
);

    localparam int unsigned NCH = 1 << IR_W;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } cmd_state_e;

    // Toggle synchronisers plus a delayed copy of the last stage
    logic [SYNC_STAGES-1:0] uir_sync_q;
    logic [SYNC_STAGES-1:0] udr_sync_q;
    logic                   uir_dly_q;
    logic                   udr_dly_q;
    logic                   uir_evt;
    logic                   udr_evt;

    cmd_state_e             state_q,      state_d;
    logic [IR_W-1:0]        ir_q,         ir_d;
    logic [DR_W-1:0]        jdo_q,        jdo_d;
    logic [IR_W-1:0]        cmd_ir_q,     cmd_ir_d;
    logic                   ir_upd_q,     ir_upd_d;
    logic [NCH-1:0]         take_act_q,   take_act_d;
    logic [NCH-1:0]         take_nact_q,  take_nact_d;
    logic                   overrun_q,    overrun_d;
    logic [CNT_W-1:0]       ovr_cnt_q,    ovr_cnt_d;

    logic                   accept;
    logic                   drop;

    // -------------------------------------------------------------------------
    // Synchronisers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            uir_dly_q  <= 1'b0;
            udr_dly_q  <= 1'b0;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir_tgl};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr_tgl};
            uir_dly_q  <= uir_sync_q[SYNC_STAGES-1];
            udr_dly_q  <= udr_sync_q[SYNC_STAGES-1];
        end
    end

    assign uir_evt = uir_sync_q[SYNC_STAGES-1] ^ uir_dly_q;
    assign udr_evt = udr_sync_q[SYNC_STAGES-1] ^ udr_dly_q;

    // -------------------------------------------------------------------------
    // Command holder, IR capture, action decode and overrun tracking
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            ir_q        <= '0;
            jdo_q       <= '0;
            cmd_ir_q    <= '0;
            ir_upd_q    <= 1'b0;
            take_act_q  <= '0;
            take_nact_q <= '0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            jdo_q       <= jdo_d;
            cmd_ir_q    <= cmd_ir_d;
            ir_upd_q    <= ir_upd_d;
            take_act_q  <= take_act_d;
            take_nact_q <= take_nact_d;
            overrun_q   <= overrun_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        jdo_d       = jdo_q;
        cmd_ir_d    = cmd_ir_q;
        take_act_d  = '0;
        take_nact_d = '0;
        overrun_d   = overrun_q;
        ovr_cnt_d   = ovr_cnt_q;
        drop        = 1'b0;

        accept   = (state_q == ST_FULL) && cmd.cmd_ready;

        // A same-cycle IR update must reach the command being loaded, so the
        // command's IR comes from ir_d rather than ir_q.
        ir_d     = uir_evt ? ir_in : ir_q;
        ir_upd_d = uir_evt;

        // Decode uses the command being accepted, before any reload below
        if (accept) begin
            if (jdo_q[DR_W-1]) begin
                take_act_d[cmd_ir_q] = 1'b1;
            end else begin
                take_nact_d[cmd_ir_q] = 1'b1;
            end
        end

        case (state_q)
            ST_EMPTY: begin
                if (udr_evt) begin
                    jdo_d    = sr;
                    cmd_ir_d = ir_d;
                    state_d  = ST_FULL;
                end
            end
            ST_FULL: begin
                if (udr_evt) begin
                    if (cmd.cmd_ready) begin
                        jdo_d    = sr;
                        cmd_ir_d = ir_d;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (cmd.cmd_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (clr_overrun) begin
            overrun_d = 1'b0;
            ovr_cnt_d = '0;
        end else if (drop) begin
            overrun_d = 1'b1;
            if (ovr_cnt_q != '1) begin
                ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cmd.cmd_valid  = (state_q == ST_FULL);
    assign cmd.jdo        = jdo_q;
    assign cmd.cmd_ir     = cmd_ir_q;
    assign ir_upd         = ir_upd_q;
    assign take_action    = take_act_q;
    assign take_no_action = take_nact_q;
    assign overrun        = overrun_q;
    assign ovr_cnt        = ovr_cnt_q;

endmodule

// File: tb/tb_jtag_debug_cmd_sysclk_gen.sv
// -----------------------------------------------------------------------------
// tb_jtag_debug_cmd_sysclk_gen
// Self-checking bench: directed scenarios with literal expectations, then a
// randomized phase, all compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_jtag_debug_cmd_sysclk_gen;

    localparam int unsigned IR_W  = 2;
    localparam int unsigned DR_W  = 38;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned NCH   = 1 << IR_W;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              vs_uir_tgl;
    logic              vs_udr_tgl;
    logic [IR_W-1:0]   ir_in;
    logic [DR_W-1:0]   sr;
    logic              ir_upd;
    logic [NCH-1:0]    take_action;
    logic [NCH-1:0]    take_no_action;
    logic              overrun;
    logic [CNT_W-1:0]  ovr_cnt;
    logic              clr_overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jtag_debug_cmd_sysclk_gen_if #(.IR_W(IR_W), .DR_W(DR_W)) cmd_if ();

    jtag_debug_cmd_sysclk_gen #(
        .IR_W(IR_W), .DR_W(DR_W), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_uir_tgl     (vs_uir_tgl),
        .vs_udr_tgl     (vs_udr_tgl),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd            (cmd_if),
        .ir_upd         (ir_upd),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .overrun        (overrun),
        .ovr_cnt        (ovr_cnt),
        .clr_overrun    (clr_overrun)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model. Each toggle input is remembered as the level seen at
    // each clock edge; a change between two samples becomes visible to the
    // command logic SYNC edges after the edge that first saw the new level.
    // -------------------------------------------------------------------------
    bit              hu[$];
    bit              hd[$];
    bit              m_pend  = 0;
    logic [DR_W-1:0] m_jdo   = '0;
    int              m_cir   = 0;
    int              m_ir    = 0;
    bit              m_iru   = 0;
    logic [NCH-1:0]  m_ta    = '0;
    logic [NCH-1:0]  m_tna   = '0;
    bit              m_ovr   = 0;
    int              m_cnt   = 0;

    function automatic bit seen_change(input bit older, input bit newer);
        return older ^ newer;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hu.delete(); hd.delete();
            m_pend = 0; m_jdo = '0; m_cir = 0; m_ir = 0; m_iru = 0;
            m_ta = '0; m_tna = '0; m_ovr = 0; m_cnt = 0;
        end else begin
            bit ue, de, acc, drp;
            int n, a, b;
            hu.push_back(vs_uir_tgl);
            hd.push_back(vs_udr_tgl);
            if (hu.size() > SYNC + 2) void'(hu.pop_front());
            if (hd.size() > SYNC + 2) void'(hd.pop_front());
            n = hu.size();
            a = n - 1 - SYNC;
            b = n - 2 - SYNC;
            ue = seen_change((b >= 0) ? hu[b] : 1'b0, (a >= 0) ? hu[a] : 1'b0);
            de = seen_change((b >= 0) ? hd[b] : 1'b0, (a >= 0) ? hd[a] : 1'b0);

            acc = m_pend && cmd_if.cmd_ready;
            m_ta  = '0;
            m_tna = '0;
            if (acc) begin
                if (m_jdo[DR_W-1]) m_ta  = NCH'(1) << m_cir;
                else               m_tna = NCH'(1) << m_cir;
            end

            m_iru = ue;
            if (ue) m_ir = int'(ir_in);

            drp = 0;
            if (de) begin
                if (!m_pend || cmd_if.cmd_ready) begin
                    m_jdo  = sr;
                    m_cir  = m_ir;
                    m_pend = 1;
                end else begin
                    drp = 1;
                end
            end else if (acc) begin
                m_pend = 0;
            end

            if (clr_overrun) begin
                m_ovr = 0;
                m_cnt = 0;
            end else if (drp) begin
                m_ovr = 1;
                if (m_cnt < CMAX) m_cnt++;
            end
        end
    end

    // Every-cycle comparison against the model, 1 time unit after the edge
    always @(posedge clk) begin
        #1;
        chk("m_cmd_valid",  64'(cmd_if.cmd_valid), 64'(m_pend));
        chk("m_jdo",        64'(cmd_if.jdo),       64'(m_jdo));
        chk("m_cmd_ir",     64'(cmd_if.cmd_ir),    64'(m_cir));
        chk("m_ir_upd",     64'(ir_upd),           64'(m_iru));
        chk("m_take_act",   64'(take_action),      64'(m_ta));
        chk("m_take_nact",  64'(take_no_action),   64'(m_tna));
        chk("m_overrun",    64'(overrun),          64'(m_ovr));
        chk("m_ovr_cnt",    64'(ovr_cnt),          64'(m_cnt));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus with hand-computed expectations
    // -------------------------------------------------------------------------
    initial begin
        int gap_u, gap_d, mode;
        reset_n = 1'b0; vs_uir_tgl = 1'b0; vs_udr_tgl = 1'b0;
        ir_in = '0; sr = '0; cmd_if.cmd_ready = 1'b0; clr_overrun = 1'b0;
        tick(3);
        chk("rst_valid", 64'(cmd_if.cmd_valid), 64'd0);
        chk("rst_jdo",   64'(cmd_if.jdo),       64'd0);
        chk("rst_cnt",   64'(ovr_cnt),          64'd0);
        reset_n = 1'b1;
        tick(2);

        // IR update
        ir_in = 2'b01; vs_uir_tgl = ~vs_uir_tgl;
        tick(2); chk("iru_early", 64'(ir_upd), 64'd0);
        tick(1); chk("iru_pulse", 64'(ir_upd), 64'd1);
        chk("iru_notake", 64'({take_action, take_no_action}), 64'd0);
        tick(1); chk("iru_once", 64'(ir_upd), 64'd0);
        tick(2);

        // Action command, consumer always ready
        sr = 38'h20_0000_1234; cmd_if.cmd_ready = 1'b1; vs_udr_tgl = ~vs_udr_tgl;
        tick(2); chk("act_latency", 64'(cmd_if.cmd_valid), 64'd0);
        tick(1); chk("act_valid",   64'(cmd_if.cmd_valid), 64'd1);
        chk("act_jdo", 64'(cmd_if.jdo),    64'h20_0000_1234);
        chk("act_ir",  64'(cmd_if.cmd_ir), 64'd1);
        tick(1); chk("act_take",  64'(take_action), 64'b0010);
        chk("act_drop_valid", 64'(cmd_if.cmd_valid), 64'd0);
        tick(1); chk("act_take_once", 64'(take_action), 64'd0);
        cmd_if.cmd_ready = 1'b0;
        tick(2);

        // No-action command held for 5 cycles
        ir_in = 2'd3; vs_uir_tgl = ~vs_uir_tgl;
        tick(5);
        sr = 38'h00_0000_00AB; vs_udr_tgl = ~vs_udr_tgl;
        tick(3);
        for (int i = 0; i < 5; i++) begin
            chk("hold_jdo", 64'(cmd_if.jdo), 64'h00_0000_00AB);
            tick(1);
        end
        cmd_if.cmd_ready = 1'b1;
        tick(1); chk("nact_take", 64'(take_no_action), 64'b1000);
        cmd_if.cmd_ready = 1'b0;
        tick(1); chk("nact_once", 64'(take_no_action), 64'd0);
        tick(2);

        // Overrun: one held command, then 300 dropped updates
        sr = 38'h15_5555_AAAA; vs_udr_tgl = ~vs_udr_tgl;
        tick(4);
        for (int i = 0; i < 300; i++) begin
            sr = DR_W'({$urandom(), $urandom()});
            vs_udr_tgl = ~vs_udr_tgl;
            tick(2);
        end
        tick(5);
        chk("ovr_jdo",  64'(cmd_if.jdo), 64'h15_5555_AAAA);
        chk("ovr_flag", 64'(overrun),    64'd1);
        chk("ovr_sat",  64'(ovr_cnt),    64'd255);
        clr_overrun = 1'b1;
        tick(1);
        chk("clr_flag", 64'(overrun), 64'd0);
        chk("clr_cnt",  64'(ovr_cnt), 64'd0);
        clr_overrun = 1'b0;
        cmd_if.cmd_ready = 1'b1; tick(2); cmd_if.cmd_ready = 1'b0; tick(2);

        // Same-cycle IR and DR updates: new IR reaches the command
        ir_in = 2'd2; sr = 38'h2A_BCDE_F012;
        vs_uir_tgl = ~vs_uir_tgl; vs_udr_tgl = ~vs_udr_tgl;
        tick(3);
        chk("same_ir",    64'(cmd_if.cmd_ir),    64'd2);
        chk("same_valid", 64'(cmd_if.cmd_valid), 64'd1);
        cmd_if.cmd_ready = 1'b1;
        tick(1); chk("same_take", 64'(take_action), 64'b0100);
        cmd_if.cmd_ready = 1'b0;
        tick(2);

        // Accept coinciding with a new DR event
        sr = 38'h3F_0000_0001; vs_udr_tgl = ~vs_udr_tgl;
        tick(4);
        sr = 38'h01_2345_6789; vs_udr_tgl = ~vs_udr_tgl;
        tick(2);
        cmd_if.cmd_ready = 1'b1;
        tick(1);
        cmd_if.cmd_ready = 1'b0;
        chk("b2b_valid", 64'(cmd_if.cmd_valid), 64'd1);
        chk("b2b_jdo",   64'(cmd_if.jdo),       64'h01_2345_6789);
        chk("b2b_take",  64'(take_action),      64'b0100);
        tick(1);
        cmd_if.cmd_ready = 1'b1;
        tick(1); chk("b2b_nact", 64'(take_no_action), 64'b0100);
        cmd_if.cmd_ready = 1'b0;
        tick(2);

        // Reset while a command is pending (toggle inputs returned to 0 first)
        vs_udr_tgl = ~vs_udr_tgl; tick(4);
        if (vs_udr_tgl) begin vs_udr_tgl = 1'b0; tick(4); end
        if (vs_uir_tgl) begin vs_uir_tgl = 1'b0; tick(4); end
        chk("rmid_pending", 64'(cmd_if.cmd_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rmid_valid", 64'(cmd_if.cmd_valid), 64'd0);
        chk("rmid_jdo",   64'(cmd_if.jdo),       64'd0);
        chk("rmid_cnt",   64'(ovr_cnt),          64'd0);
        cmd_if.cmd_ready = 1'b1;
        tick(1);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rmid_notake", 64'({take_action, take_no_action}), 64'd0);
        end
        cmd_if.cmd_ready = 1'b0;

        // Randomized traffic with slow/fast consumer phases
        gap_u = 0; gap_d = 0; mode = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c % 200 == 0) mode = $urandom_range(0, 2);
            case (mode)
                0:       cmd_if.cmd_ready = ($urandom_range(0, 7) != 0);
                1:       cmd_if.cmd_ready = ($urandom_range(0, 7) == 0);
                default: cmd_if.cmd_ready = $urandom_range(0, 1);
            endcase
            clr_overrun = ($urandom_range(0, 63) == 0);
            if (gap_u > 0) gap_u--;
            if (gap_d > 0) gap_d--;
            if (gap_u == 0 && $urandom_range(0, 4) == 0) begin
                ir_in = IR_W'($urandom());
                vs_uir_tgl = ~vs_uir_tgl;
                gap_u = SYNC + 2;
            end
            if (gap_d == 0 && $urandom_range(0, 3) == 0) begin
                sr = DR_W'({$urandom(), $urandom()});
                vs_udr_tgl = ~vs_udr_tgl;
                gap_d = SYNC + 2;
            end
        end
        cmd_if.cmd_ready = 1'b1; clr_overrun = 1'b0;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
